// File: rtl/video_pkg.sv
// Shared video constants: colour widths, pipeline latency and the 4x4 Bayer table.
package video_pkg;

  localparam int unsigned ColorInW    = 8;
  localparam int unsigned ColorOutW   = 3;
  localparam int unsigned ThreshW     = 5;
  localparam int unsigned PipeLatency = 2;
  localparam int unsigned CoordW      = 10;

  // Threshold used for every pixel when dithering is disabled (half of one output step).
  localparam logic [ThreshW-1:0] MidThreshold = 5'd16;

  // Rows indexed by vpos[1:0], columns by hpos[1:0] ^ frame[1:0].
  localparam logic [3:0] BayerTable [4][4] = '{
    '{4'd0,  4'd8,  4'd2,  4'd10},
    '{4'd12, 4'd4,  4'd14, 4'd6},
    '{4'd3,  4'd11, 4'd1,  4'd9},
    '{4'd15, 4'd7,  4'd13, 4'd5}
  };

  function automatic logic [3:0] bayer_value(input logic [1:0] row, input logic [1:0] col);
    return BayerTable[row][col];
  endfunction

endpackage

// File: rtl/dither_quantizer.sv
// Combinational per-channel quantiser: q = sat7((c + t) >> 5).
module dither_quantizer
  import video_pkg::*;
(
  input  logic [ColorInW-1:0]  c,
  input  logic [ThreshW-1:0]   t,
  output logic [ColorOutW-1:0] q
);

  logic [ColorInW:0] sum;

  // Widen before adding so the carry is kept; a carry means the result would be 8, clamp to 7.
  always_comb begin
    sum = {1'b0, c} + {{(ColorInW + 1 - ThreshW){1'b0}}, t};
    if (sum[ColorInW]) begin
      q = '1;
    end else begin
      q = sum[ColorInW-1 -: ColorOutW];
    end
  end

endmodule

// File: rtl/vga_dither_output.sv
// Two-stage VGA output stage: ordered dither / rounding of 8-bit colour to 3-bit DAC,
// with syncs, blanking and a frame-start pulse kept aligned through the pipeline.
module vga_dither_output
  import video_pkg::*;
#(
  parameter bit DITHER_EN   = 1'b1,
  parameter bit INVERT_SYNC = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_hsync,
  input  logic                 i_vsync,
  input  logic                 i_visible,
  input  logic [CoordW-1:0]    i_hpos,
  input  logic [CoordW-1:0]    i_vpos,
  input  logic [ColorInW-1:0]  i_r,
  input  logic [ColorInW-1:0]  i_g,
  input  logic [ColorInW-1:0]  i_b,
  output logic                 o_vga_hsync,
  output logic                 o_vga_vsync,
  output logic [ColorOutW-1:0] o_vga_r,
  output logic [ColorOutW-1:0] o_vga_g,
  output logic [ColorOutW-1:0] o_vga_b,
  output logic                 o_frame_start
);

  // Stage 1 registers
  logic                s1_hsync_q;
  logic                s1_vsync_q;
  logic                s1_visible_q;
  logic                s1_frame_start_q;
  logic [ColorInW-1:0] s1_r_q, s1_g_q, s1_b_q;
  logic [ThreshW-1:0]  s1_thresh_q;
  logic [1:0]          frame_q;

  logic [ThreshW-1:0]   thresh_d;
  logic [1:0]           bayer_col;
  logic                 vsync_rise;
  logic [ColorOutW-1:0] q_r, q_g, q_b;

  // Only the low two coordinate bits select the Bayer cell.
  logic unused_pos;
  assign unused_pos = ^{i_hpos[CoordW-1:2], i_vpos[CoordW-1:2]};

  // s1_vsync_q doubles as the prior-vsync of the edge detector; it resets to 0.
  assign vsync_rise = i_vsync & ~s1_vsync_q;

  // Per-pixel threshold from the frame-shifted Bayer cell, or a fixed rounding point.
  always_comb begin
    bayer_col = i_hpos[1:0] ^ frame_q;
    if (DITHER_EN) begin
      thresh_d = {bayer_value(i_vpos[1:0], bayer_col), 1'b0};
    end else begin
      thresh_d = MidThreshold;
    end
  end

  // Stage 1: register inputs, threshold, and advance frame on a vsync rising edge.
  // The threshold latched on the edge cycle still uses the old frame value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_hsync_q       <= 1'b0;
      s1_vsync_q       <= 1'b0;
      s1_visible_q     <= 1'b0;
      s1_frame_start_q <= 1'b0;
      s1_r_q           <= '0;
      s1_g_q           <= '0;
      s1_b_q           <= '0;
      s1_thresh_q      <= '0;
      frame_q          <= 2'd0;
    end else begin
      s1_hsync_q       <= i_hsync;
      s1_vsync_q       <= i_vsync;
      s1_visible_q     <= i_visible;
      s1_frame_start_q <= vsync_rise;
      s1_r_q           <= i_r;
      s1_g_q           <= i_g;
      s1_b_q           <= i_b;
      s1_thresh_q      <= thresh_d;
      if (vsync_rise) begin
        frame_q <= frame_q + 2'd1;
      end
    end
  end

  dither_quantizer u_quant_r (
    .c (s1_r_q),
    .t (s1_thresh_q),
    .q (q_r)
  );

  dither_quantizer u_quant_g (
    .c (s1_g_q),
    .t (s1_thresh_q),
    .q (q_g)
  );

  dither_quantizer u_quant_b (
    .c (s1_b_q),
    .t (s1_thresh_q),
    .q (q_b)
  );

  // Stage 2: register blanked colour, board-polarity syncs and the frame-start pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vga_hsync   <= INVERT_SYNC;
      o_vga_vsync   <= INVERT_SYNC;
      o_vga_r       <= '0;
      o_vga_g       <= '0;
      o_vga_b       <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_vga_hsync   <= s1_hsync_q ^ INVERT_SYNC;
      o_vga_vsync   <= s1_vsync_q ^ INVERT_SYNC;
      o_vga_r       <= s1_visible_q ? q_r : '0;
      o_vga_g       <= s1_visible_q ? q_g : '0;
      o_vga_b       <= s1_visible_q ? q_b : '0;
      o_frame_start <= s1_frame_start_q;
    end
  end

endmodule

// File: tb/tb_vga_dither_output.sv
// Directed bench for vga_dither_output: dithered, rounding-only and inverted-sync builds
// share one stimulus stream.
module tb_vga_dither_output;

  logic       clk;
  logic       rst;
  logic       hsync, vsync, visible;
  logic [9:0] hpos, vpos;
  logic [7:0] r, g, b;

  logic       d_hs, d_vs, d_fs;
  logic [2:0] d_r, d_g, d_b;
  logic       n_hs, n_vs, n_fs;
  logic [2:0] n_r, n_g, n_b;
  logic       v_hs, v_vs, v_fs;
  logic [2:0] v_r, v_g, v_b;

  int n_checks = 0;
  int n_errors = 0;
  int fs_count = 0;
  bit fs_count_en = 1'b0;

  vga_dither_output dut (
    .i_clk (clk), .i_rst (rst), .i_hsync (hsync), .i_vsync (vsync), .i_visible (visible),
    .i_hpos (hpos), .i_vpos (vpos), .i_r (r), .i_g (g), .i_b (b),
    .o_vga_hsync (d_hs), .o_vga_vsync (d_vs), .o_vga_r (d_r), .o_vga_g (d_g),
    .o_vga_b (d_b), .o_frame_start (d_fs)
  );

  vga_dither_output #(.DITHER_EN(1'b0)) dut_nd (
    .i_clk (clk), .i_rst (rst), .i_hsync (hsync), .i_vsync (vsync), .i_visible (visible),
    .i_hpos (hpos), .i_vpos (vpos), .i_r (r), .i_g (g), .i_b (b),
    .o_vga_hsync (n_hs), .o_vga_vsync (n_vs), .o_vga_r (n_r), .o_vga_g (n_g),
    .o_vga_b (n_b), .o_frame_start (n_fs)
  );

  vga_dither_output #(.INVERT_SYNC(1'b1)) dut_inv (
    .i_clk (clk), .i_rst (rst), .i_hsync (hsync), .i_vsync (vsync), .i_visible (visible),
    .i_hpos (hpos), .i_vpos (vpos), .i_r (r), .i_g (g), .i_b (b),
    .o_vga_hsync (v_hs), .o_vga_vsync (v_vs), .o_vga_r (v_r), .o_vga_g (v_g),
    .o_vga_b (v_b), .o_frame_start (v_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame-start pulses away from the active edge.
  always @(negedge clk) begin
    if (fs_count_en && d_fs === 1'b1) fs_count++;
  end

  typedef struct {
    logic       vis;
    logic [9:0] h, v;
    logic [7:0] r, g, b;
    logic [2:0] dr, dg, db;
    logic [2:0] nr, ng, nb;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_pixel(input logic vis, input logic [9:0] h, input logic [9:0] v,
                             input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    visible = vis; hpos = h; vpos = v; r = cr; g = cg; b = cb;
  endtask

  initial begin
    // vis, h, v, r, g, b, dithered r/g/b (frame 0), rounded r/g/b
    vecs[0] = '{1'b1, 10'd0, 10'd0, 8'd0,   8'd15,  8'd16,  3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    vecs[1] = '{1'b1, 10'd0, 10'd0, 8'd144, 8'd255, 8'd144, 3'd4, 3'd7, 3'd4, 3'd5, 3'd7, 3'd5};
    vecs[2] = '{1'b1, 10'd3, 10'd1, 8'd144, 8'd144, 8'd0,   3'd4, 3'd4, 3'd0, 3'd5, 3'd5, 3'd0};
    vecs[3] = '{1'b1, 10'd2, 10'd1, 8'd144, 8'd255, 8'd16,  3'd5, 3'd7, 3'd1, 3'd5, 3'd7, 3'd1};
    vecs[4] = '{1'b0, 10'd2, 10'd1, 8'd255, 8'd255, 8'd255, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[5] = '{1'b1, 10'd1, 10'd3, 8'd18,  8'd100, 8'd200, 3'd1, 3'd3, 3'd6, 3'd1, 3'd3, 3'd6};
    vecs[6] = '{1'b1, 10'd7, 10'd10, 8'd14, 8'd13,  8'd240, 3'd1, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7};
    vecs[7] = '{1'b1, 10'd0, 10'd3, 8'd0,   8'd2,   8'd1,   3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

    rst = 1'b1; hsync = 1'b0; vsync = 1'b0;
    drive_pixel(1'b0, 10'd0, 10'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();

    // Reset state
    check("rst_r", d_r, 0); check("rst_g", d_g, 0); check("rst_b", d_b, 0);
    check("rst_fs", d_fs, 0);
    check("rst_hs", d_hs, 0); check("rst_vs", d_vs, 0);
    check("rst_inv_hs", v_hs, 1); check("rst_inv_vs", v_vs, 1);
    rst = 1'b0;
    tick();

    // Quantise table, frame 0
    for (int i = 0; i < 8; i++) begin
      drive_pixel(vecs[i].vis, vecs[i].h, vecs[i].v, vecs[i].r, vecs[i].g, vecs[i].b);
      tick(); tick();
      check($sformatf("vec%0d_dr", i), d_r, vecs[i].dr);
      check($sformatf("vec%0d_dg", i), d_g, vecs[i].dg);
      check($sformatf("vec%0d_db", i), d_b, vecs[i].db);
      check($sformatf("vec%0d_nr", i), n_r, vecs[i].nr);
      check($sformatf("vec%0d_ng", i), n_g, vecs[i].ng);
      check($sformatf("vec%0d_nb", i), n_b, vecs[i].nb);
    end

    // Latency: single-cycle hsync + visible pulse appears only two clocks later
    drive_pixel(1'b0, 10'd0, 10'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    hsync = 1'b1;
    drive_pixel(1'b1, 10'd0, 10'd0, 8'd255, 8'd255, 8'd255);
    tick();
    hsync = 1'b0;
    drive_pixel(1'b0, 10'd0, 10'd0, 8'd255, 8'd255, 8'd255);
    check("lat_n1_hs", d_hs, 0); check("lat_n1_r", d_r, 0); check("lat_n1_inv_hs", v_hs, 1);
    tick();
    check("lat_n2_hs", d_hs, 1); check("lat_n2_r", d_r, 7); check("lat_n2_inv_hs", v_hs, 0);
    check("lat_n2_vs", d_vs, 0);
    tick();
    check("lat_n3_hs", d_hs, 0); check("lat_n3_r", d_r, 0); check("lat_n3_inv_hs", v_hs, 1);
    check("blank_inv_b", v_b, 0);

    // Five vsync rising edges, the third held high ten cycles
    fs_count_en = 1'b1;
    for (int p = 0; p < 5; p++) begin
      vsync = 1'b1;
      repeat ((p == 2) ? 10 : 2) tick();
      vsync = 1'b0;
      repeat (3) tick();
    end
    repeat (3) tick();
    fs_count_en = 1'b0;
    check("frame_start_count", fs_count[7:0], 5);

    // frame = 1: column index is hpos ^ 1
    drive_pixel(1'b1, 10'd2, 10'd1, 8'd144, 8'd144, 8'd144);
    tick(); tick();
    check("f1_h2v1_r", d_r, 4);
    drive_pixel(1'b1, 10'd3, 10'd1, 8'd144, 8'd144, 8'd144);
    tick(); tick();
    check("f1_h3v1_r", d_r, 5);

    // Pixel sampled on the vsync edge uses old frame (1), the next one the new frame (2)
    drive_pixel(1'b1, 10'd2, 10'd1, 8'd144, 8'd144, 8'd144);
    vsync = 1'b1;
    tick();
    tick();
    check("edge_pix_r", d_r, 4); check("edge_fs", d_fs, 1); check("edge_vs", d_vs, 1);
    tick();
    check("after_edge_r", d_r, 5); check("after_edge_fs", d_fs, 0);
    vsync = 1'b0;
    tick(); tick();

    // Asynchronous reset clears outputs without a clock edge
    drive_pixel(1'b1, 10'd0, 10'd0, 8'd255, 8'd255, 8'd255);
    hsync = 1'b1;
    tick(); tick();
    check("pre_rst_r", d_r, 7);
    rst = 1'b1;
    #1;
    check("async_rst_r", d_r, 0); check("async_rst_hs", d_hs, 0);
    check("async_rst_inv_hs", v_hs, 1);
    for (int k = 0; k < 3; k++) begin
      hsync = 1'($urandom); vsync = 1'($urandom);
      drive_pixel(1'($urandom), 10'($urandom), 10'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom));
      tick();
      check("inrst_g", d_g, 0); check("inrst_fs", d_fs, 0);
      check("inrst_vs", d_vs, 0); check("inrst_inv_vs", v_vs, 1);
    end

    // Release with vsync already high: one frame_start, first valid output two clocks later
    hsync = 1'b0; vsync = 1'b1;
    drive_pixel(1'b1, 10'd0, 10'd0, 8'd255, 8'd255, 8'd255);
    rst = 1'b0;
    tick();
    check("rel1_r", d_r, 0); check("rel1_fs", d_fs, 0);
    tick();
    check("rel2_r", d_r, 7); check("rel2_fs", d_fs, 1);
    tick();
    check("rel3_fs", d_fs, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
